// File: rtl/rename_reg_file_pkg.sv
// Shared sizing defaults and packed-vector slice helpers for the rename register file.
`ifndef RENAME_REG_FILE_PKG_SV
`define RENAME_REG_FILE_PKG_SV

// Select element IDX of width W from a flat packed port vector.
`define RRF_SLICE(VEC, IDX, W) VEC[(IDX)*(W) +: (W)]

package rename_reg_file_pkg;
  localparam int REG_NUM_DEF    = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int ROB_IDX_W_DEF  = 4;
  localparam int NUM_READ_DEF   = 2;
  localparam int NUM_COMMIT_DEF = 2;
  localparam int REG_IDX_W      = $clog2(REG_NUM_DEF);
endpackage

`endif

// File: rtl/rrf_bypass_mux.sv
// One operand read port: x0 forcing, commit-to-read bypass, else architectural state.
module rrf_bypass_mux
  import rename_reg_file_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROB_IDX_W  = ROB_IDX_W_DEF,
  parameter int NUM_COMMIT = NUM_COMMIT_DEF,
  parameter int RIDX_W     = REG_IDX_W
) (
  input  logic [RIDX_W-1:0]                rd_idx,
  input  logic [DATA_W-1:0]                reg_val,
  input  logic                             reg_busy,
  input  logic [ROB_IDX_W-1:0]             reg_tag,
  input  logic [NUM_COMMIT-1:0]            cm_valid,
  input  logic [NUM_COMMIT*RIDX_W-1:0]     cm_rd,
  input  logic [NUM_COMMIT*ROB_IDX_W-1:0]  cm_tag,
  input  logic [NUM_COMMIT*DATA_W-1:0]     cm_val,
  output logic [DATA_W-1:0]                rd_val,
  output logic                             rd_busy,
  output logic [ROB_IDX_W-1:0]             rd_tag
);

  logic              w_hit;
  logic [DATA_W-1:0] w_byp_val;

  // Find a commit retiring the pending rename; later ports overwrite, so the highest k wins.
  always_comb begin
    w_hit     = 1'b0;
    w_byp_val = '0;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      if (cm_valid[k] &&
          (`RRF_SLICE(cm_rd, k, RIDX_W) == rd_idx) &&
          (`RRF_SLICE(cm_tag, k, ROB_IDX_W) == reg_tag)) begin
        w_hit     = 1'b1;
        w_byp_val = `RRF_SLICE(cm_val, k, DATA_W);
      end
    end
  end

  // Final operand select; x0 is always zero and never pending.
  always_comb begin
    rd_val  = '0;
    rd_busy = 1'b0;
    rd_tag  = '0;
    if (rd_idx != '0) begin
      if (reg_busy && w_hit) begin
        rd_val = w_byp_val;
      end else begin
        rd_val  = reg_val;
        rd_busy = reg_busy;
        rd_tag  = reg_busy ? reg_tag : '0;
      end
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags, multi-port commit and misprediction flush.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter  int REG_NUM    = REG_NUM_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int ROB_IDX_W  = ROB_IDX_W_DEF,
  parameter  int NUM_READ   = NUM_READ_DEF,
  parameter  int NUM_COMMIT = NUM_COMMIT_DEF,
  localparam int RIDX_W     = $clog2(REG_NUM)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             issue_valid,
  input  logic [RIDX_W-1:0]                issue_rd,
  input  logic [ROB_IDX_W-1:0]             issue_tag,
  input  logic [NUM_READ*RIDX_W-1:0]       rd_idx,
  output logic [NUM_READ*DATA_W-1:0]       rd_val,
  output logic [NUM_READ-1:0]              rd_busy,
  output logic [NUM_READ*ROB_IDX_W-1:0]    rd_tag,
  input  logic [NUM_COMMIT-1:0]            cm_valid,
  input  logic [NUM_COMMIT*RIDX_W-1:0]     cm_rd,
  input  logic [NUM_COMMIT*ROB_IDX_W-1:0]  cm_tag,
  input  logic [NUM_COMMIT*DATA_W-1:0]     cm_val,
  input  logic                             flush
);

  logic [REG_NUM-1:0][DATA_W-1:0]    r_val,  w_val_nxt;
  logic [REG_NUM-1:0]                r_busy, w_busy_nxt;
  logic [REG_NUM-1:0][ROB_IDX_W-1:0] r_tag,  w_tag_nxt;

  // Next state: commits in port order, then issue, then flush wipes all renames.
  always_comb begin
    w_val_nxt  = r_val;
    w_busy_nxt = r_busy;
    w_tag_nxt  = r_tag;
    for (int k = 0; k < NUM_COMMIT; k++) begin
      if (cm_valid[k] && (`RRF_SLICE(cm_rd, k, RIDX_W) != '0)) begin
        w_val_nxt[`RRF_SLICE(cm_rd, k, RIDX_W)] = `RRF_SLICE(cm_val, k, DATA_W);
        // Only the commit of the current rename may clear busy; older producers leave it.
        if (r_busy[`RRF_SLICE(cm_rd, k, RIDX_W)] &&
            (r_tag[`RRF_SLICE(cm_rd, k, RIDX_W)] == `RRF_SLICE(cm_tag, k, ROB_IDX_W)))
          w_busy_nxt[`RRF_SLICE(cm_rd, k, RIDX_W)] = 1'b0;
      end
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
      w_tag_nxt[issue_rd]  = issue_tag;
    end
    if (flush) begin
      w_busy_nxt = '0;
      w_tag_nxt  = '0;
    end
  end

  // State registers; hold whenever the global enable is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_val  <= '0;
      r_busy <= '0;
      r_tag  <= '0;
    end else if (rdy_in) begin
      r_val  <= w_val_nxt;
      r_busy <= w_busy_nxt;
      r_tag  <= w_tag_nxt;
    end
  end

  // One bypass/select slice per read port.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [RIDX_W-1:0] w_idx;
    assign w_idx = `RRF_SLICE(rd_idx, p, RIDX_W);

    rrf_bypass_mux #(
      .DATA_W    (DATA_W),
      .ROB_IDX_W (ROB_IDX_W),
      .NUM_COMMIT(NUM_COMMIT),
      .RIDX_W    (RIDX_W)
    ) u_mux (
      .rd_idx  (w_idx),
      .reg_val (r_val[w_idx]),
      .reg_busy(r_busy[w_idx]),
      .reg_tag (r_tag[w_idx]),
      .cm_valid(cm_valid),
      .cm_rd   (cm_rd),
      .cm_tag  (cm_tag),
      .cm_val  (cm_val),
      .rd_val  (`RRF_SLICE(rd_val, p, DATA_W)),
      .rd_busy (rd_busy[p]),
      .rd_tag  (`RRF_SLICE(rd_tag, p, ROB_IDX_W))
    );
  end

endmodule
